pulse_stretcher: RTL
====================

// Module: pulse_stretcher
// PURPOSE
//  Output-side counterpart of the input debouncer. Turns short internal event pulses (1+ cycles)
//  into long, human-visible output pulses, e.g. for LEDs or a scope pin. Multi-channel, with a
//  shared tick prescaler, a minimum low gap between stretched pulses, and a one-deep pending latch.
//  Sits between core status strobes and the board LED/GPIO pins.
// PARAMETERS
//  WIDTH         1      number of independent channels
//  TICK_CNT_MAX  62500  tick period in clk cycles (>=1; 1 = tick every cycle)
//  ON_TICKS      200    high time in ticks (>=1)
//  GAP_TICKS     50     forced low time after each high pulse, in ticks (0 = no gap state)
//  RETRIGGER     1      1: pulse while ON reloads ON_TICKS; 0: it is latched as pending
//  TICK_W / ON_W        derived: $clog2(TICK_CNT_MAX), $clog2(max(ON_TICKS,GAP_TICKS)+1)
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous, active-high reset
//  pulse_in       in   WIDTH  event strobes; level-sampled, every high cycle is one event
//  stretched_out  out  WIDTH  registered stretched output (high iff channel in ON)
//  busy           out  WIDTH  registered; high iff channel not IDLE
// BEHAVIOUR
//  Reset: tick_cnt=0, all channels IDLE, counters=0, pending=0, stretched_out=0, busy=0.
//   pulse_in ignored while rst=1. Reset mid-ON/GAP: outputs are 0 at the next edge.
//  Tick: tick_cnt counts 0..TICK_CNT_MAX-1 and wraps. tick=1 for one cycle when
//   tick_cnt==TICK_CNT_MAX-1. Shared by all channels and free-running.
//  Per-channel FSM {IDLE, ON, GAP}, one counter cnt, pending bit:
//   IDLE: pulse_in -> ON, cnt=ON_TICKS. Output is high the cycle after the pulse (latency 1).
//   ON: on tick, cnt==1 is expiry; otherwise cnt decrements.
//    Expiry goes to GAP with cnt=GAP_TICKS, or if GAP_TICKS==0 goes to (pending ? ON : IDLE).
//    pulse_in with RETRIGGER=1: cnt=ON_TICKS. This wins over a simultaneous expiry.
//    pulse_in with RETRIGGER=0: pending=1. A simultaneous expiry still proceeds.
//   GAP: output low. pulse_in -> pending=1. On tick, cnt==1 is expiry; otherwise cnt decrements.
//    Expiry: if (pending | pulse_in) -> ON, cnt=ON_TICKS, pending=0; else -> IDLE.
//   Pending is one deep. Further pulses while pending=1 are dropped.
//   Any re-entry into ON consumes pending.
//  High time is between (ON_TICKS-1)*TICK_CNT_MAX+1 and ON_TICKS*TICK_CNT_MAX cycles,
//   depending on tick phase. Gap time is bounded the same way with GAP_TICKS.
//  pulse_in held high: IDLE->ON. With RETRIGGER=1 the output stays high while held and for
//   ~ON_TICKS after release. With RETRIGGER=0 it repeats ON/GAP bursts.
//  Channels are fully independent except for the shared tick.
// STRUCTURE
//  Shared io_circuits defines header: FSM state encoding localparams (IDLE=0, ON=1, GAP=2).
//  Sub-module tick_generator #(TICK_CNT_MAX): clk, rst -> tick. Reusable by the debouncer.
//  Per-channel FSM, counter and pending bit live in a generate loop. All outputs come from flops.
// TESTING  (WIDTH=2, TICK_CNT_MAX=4, ON_TICKS=3, GAP_TICKS=2, rst released at cycle 0,
//          so ticks fall on cycles 3, 7, 11, ...)
//  1. ch0 pulse at cyc1 -> out0 high cyc2..11. GAP cyc12..19. busy0 low from cyc20. ch1 stays 0.
//  2. RETRIGGER=1: ch0 pulses at cyc1 and cyc9 -> out0 high cyc2..19 continuously, low at cyc20.
//  3. RETRIGGER=0: same stimulus as 2 -> out0 high cyc2..11, low cyc12..19,
//     high cyc20..31, busy0 low at cyc40.
//  4. Three pulses during GAP (cyc13, 14, 16) -> exactly one re-fire at cyc20.
//     A later pulse at cyc17 is dropped. Out0 is low from cyc32.
//  5. rst=1 at cyc5 with pulse_in held high through cyc8 -> out0=busy0=0 from cyc6.
//     After release, re-fires the cycle after the first non-reset high sample.
//  6. ch0 expiry tick coincides with ch1 pulse and a ch0 RETRIGGER pulse
//     -> ch0 stays ON reloaded, ch1 enters ON, and the two channels have independent timing.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: per-channel FSM state encoding
// and small constant helpers used to size counters from parameters.
package pulse_stretcher_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that counts 0..maxVal-1; never narrower than one bit
    // so a prescaler of 1 still has a legal (constant-zero) register.
    function automatic int counterWidth(input int maxVal);
        return (maxVal > 1) ? $clog2(maxVal) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher_tick_generator.sv
// Free-running prescaler: asserts o_tick for one cycle every TICK_CNT_MAX
// clock cycles. Shared by all stretcher channels and reusable by the debouncer.
module tick_generator
    import pulse_stretcher_pkg::*;
#(
    parameter int TICK_CNT_MAX = 62500
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int TICK_W = counterWidth(TICK_CNT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT_MAX - 1);

    logic [TICK_W-1:0] r_tickCnt;
    logic              w_atLast;

    assign w_atLast = (r_tickCnt == TICK_LAST);
    assign o_tick   = w_atLast;

    // Count 0..TICK_CNT_MAX-1 and wrap; reset restarts the phase at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tickCnt <= '0;
        end else if (w_atLast) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: turns short event strobes into long,
// human-visible pulses with a forced low gap and a one-deep pending latch.
// Every channel runs its own IDLE/ON/GAP machine off one shared tick.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int TICK_CNT_MAX = 62500,
    parameter int ON_TICKS     = 200,
    parameter int GAP_TICKS    = 50,
    parameter int RETRIGGER    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pulse_in,
    output logic [WIDTH-1:0] o_stretched_out,
    output logic [WIDTH-1:0] o_busy
);

    localparam int ON_W = $clog2(maxInt(ON_TICKS, GAP_TICKS) + 1);
    localparam logic [ON_W-1:0] ON_LOAD  = ON_W'(ON_TICKS);
    localparam logic [ON_W-1:0] GAP_LOAD = ON_W'(GAP_TICKS);
    localparam logic [ON_W-1:0] CNT_ONE  = ON_W'(1);

    logic w_tick;

    tick_generator #(
        .TICK_CNT_MAX(TICK_CNT_MAX)
    ) u_tickGen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_tick(w_tick)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan

        logic [1:0]      r_state;
        logic [1:0]      w_nextState;
        logic [ON_W-1:0] r_cnt;
        logic [ON_W-1:0] w_nextCnt;
        logic            r_pending;
        logic            w_nextPending;
        logic            r_stretched;
        logic            r_busy;

        // Next-state logic: ON/GAP count down on ticks; a retrigger pulse
        // beats a coinciding expiry, otherwise pulses latch into pending
        // and the first re-entry into ON consumes it.
        always_comb begin
            w_nextState   = r_state;
            w_nextCnt     = r_cnt;
            w_nextPending = r_pending;
            case (r_state)
                ST_IDLE: begin
                    if (i_pulse_in[g]) begin
                        w_nextState   = ST_ON;
                        w_nextCnt     = ON_LOAD;
                        w_nextPending = 1'b0;
                    end
                end
                ST_ON: begin
                    if ((RETRIGGER != 0) && i_pulse_in[g]) begin
                        w_nextCnt = ON_LOAD;
                    end else begin
                        if (i_pulse_in[g]) begin
                            w_nextPending = 1'b1;
                        end
                        if (w_tick) begin
                            if (r_cnt == CNT_ONE) begin
                                if (GAP_TICKS > 0) begin
                                    w_nextState = ST_GAP;
                                    w_nextCnt   = GAP_LOAD;
                                end else if (w_nextPending) begin
                                    w_nextState   = ST_ON;
                                    w_nextCnt     = ON_LOAD;
                                    w_nextPending = 1'b0;
                                end else begin
                                    w_nextState = ST_IDLE;
                                    w_nextCnt   = '0;
                                end
                            end else begin
                                w_nextCnt = r_cnt - CNT_ONE;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (i_pulse_in[g]) begin
                        w_nextPending = 1'b1;
                    end
                    if (w_tick) begin
                        if (r_cnt == CNT_ONE) begin
                            if (w_nextPending) begin
                                w_nextState   = ST_ON;
                                w_nextCnt     = ON_LOAD;
                                w_nextPending = 1'b0;
                            end else begin
                                w_nextState = ST_IDLE;
                                w_nextCnt   = '0;
                            end
                        end else begin
                            w_nextCnt = r_cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_nextState   = ST_IDLE;
                    w_nextCnt     = '0;
                    w_nextPending = 1'b0;
                end
            endcase
        end

        // State, counter and pending registers; outputs are decoded from the
        // next state so they are flops that always agree with r_state.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_pending   <= 1'b0;
                r_stretched <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                r_state     <= w_nextState;
                r_cnt       <= w_nextCnt;
                r_pending   <= w_nextPending;
                r_stretched <= (w_nextState == ST_ON);
                r_busy      <= (w_nextState != ST_IDLE);
            end
        end

        assign o_stretched_out[g] = r_stretched;
        assign o_busy[g]          = r_busy;

    end

endmodule
